// File: rtl/aes_enc_scheduler.sv
// Issue/flow control, credit tracking and result FIFO for a pipelined AES-128 core.
// Define ENC_SCHED_STATS_EN to enable the saturating blk_count statistic.
module aes_enc_scheduler #(
  parameter int PIPE_LAT   = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           key_valid,
  input  logic [1407:0]  key_in,
  output logic           key_ack,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_data,
  output logic [1407:0]  core_key,
  output logic [128:0]   core_data,
  input  logic [128:0]   core_cipher,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_data,
  output logic           busy,
  output logic [31:0]    blk_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   in_flight;
  logic [CW-1:0]   fifo_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [127:0]    mem [FIFO_DEPTH];
  logic [127:0]    head_nxt;
  logic [CW:0]     used;
  logic            credit_ok;
  logic            issue;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            drained;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every block in the core already owns a FIFO slot, so the core never overruns it.
  assign used      = {1'b0, in_flight} + {1'b0, fifo_cnt};
  assign credit_ok = used < (CW + 1)'(FIFO_DEPTH);
  assign in_ready  = (state == RUN) && !key_valid && credit_ok;
  assign issue     = in_ready && in_valid;
  assign core_data = {issue, issue ? in_data : 128'b0};

  assign push      = core_cipher[128];
  assign pop       = out_valid && out_ready;
  assign out_valid = fifo_cnt != '0;
  assign fifo_full = fifo_cnt == CW'(FIFO_DEPTH);
  assign busy      = (in_flight != '0) || out_valid || (state != RUN);

  // The last in-flight block returning this cycle lets the key swap at this edge.
  assign drained = (in_flight == '0) ||
                   ((in_flight == CW'(1)) && push);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= NOKEY;
      core_key <= '0;
      key_ack  <= 1'b0;
    end else begin
      key_ack <= 1'b0;
      unique case (state)
        NOKEY: begin
          if (key_valid) begin
            core_key <= key_in;
            key_ack  <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (key_valid && !key_ack)
            state <= DRAIN;
        end
        DRAIN: begin
          if (drained) begin
            core_key <= key_in;
            key_ack  <= 1'b1;
            state    <= RUN;
          end
        end
        default: state <= NOKEY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      in_flight <= '0;
    end else begin
      unique case ({issue, push})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= core_cipher[127:0];
  end

  always_comb begin
    head_nxt = out_data;
    unique case (1'b1)
      pop && (fifo_cnt > CW'(1)):
        head_nxt = mem[ptr_inc(rd_ptr)];
      push && ((fifo_cnt == '0) || (pop && (fifo_cnt == CW'(1)))):
        head_nxt = core_cipher[127:0];
      default:
        head_nxt = out_data;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      out_data <= '0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      out_data <= head_nxt;
    end
  end

`ifdef ENC_SCHED_STATS_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      blk_count <= '0;
    else if (push && (blk_count != 32'hFFFF_FFFF))
      blk_count <= blk_count + 32'd1;
  end
`else
  assign blk_count = 32'h0;
`endif

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!n_rst) !(push && fifo_full));

  a_flight_bound: assert property (
    @(posedge clk) disable iff (!n_rst) int'(in_flight) <= PIPE_LAT);

endmodule

// File: tb/tb_aes_enc_scheduler.sv
// Scoreboard bench for aes_enc_scheduler with a behavioural AES core model.
module tb_aes_enc_scheduler;

  localparam int PIPE_LAT   = 10;
  localparam int FIFO_DEPTH = 16;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          key_valid;
  logic [1407:0] key_in;
  logic          key_ack;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic [1407:0] core_key;
  logic [128:0]  core_data;
  logic [128:0]  core_cipher;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic          busy;
  logic [31:0]   blk_count;

  aes_enc_scheduler #(
    .PIPE_LAT   (PIPE_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .key_valid   (key_valid),
    .key_in      (key_in),
    .key_ack     (key_ack),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .core_key    (core_key),
    .core_data   (core_data),
    .core_cipher (core_cipher),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .blk_count   (blk_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int pushes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]    sbox [256];
  logic [127:0]  exp_q [$];
  int            pop_cyc [$];
  logic [1407:0] ref_key = '0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [1407:0] key_expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] ek;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ek[1407-32*i -: 32] = w[i];
    return ek;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt,
                                           input logic [1407:0] ek);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] st;
    st = pt ^ ek[1407 -: 128];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[4*c+rr] = s[4*((c+rr)%4)+rr];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r != 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = s[i];
      st = st ^ ek[1407-128*r -: 128];
    end
    return st;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Behavioural core: fixed latency, shares the scheduler's reset.
  logic [128:0] pipe [PIPE_LAT];
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= core_data[128] ?
                 {1'b1, aes_enc(core_data[127:0], core_key)} : 129'b0;
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign core_cipher = pipe[PIPE_LAT-1];

  initial forever begin
    logic [127:0] e;
    @(negedge clk);
    if (n_rst) begin
      if (in_valid && in_ready) exp_q.push_back(aes_enc(in_data, ref_key));
      if (core_cipher[128]) pushes++;
      if (out_valid && out_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk1("sb_unexpected_output", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", out_data, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, output int acc);
    in_valid = 1'b1;
    in_data  = d;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk1("send_timeout", 1'b1, 1'b0);
    tick();
  endtask

  task automatic load_key(input logic [1407:0] k, output int ack_cyc);
    key_valid = 1'b1;
    key_in    = k;
    ack_cyc   = -1;
    #1;
    chk1("key_req_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (key_ack) begin
        ack_cyc   = cyc;
        ref_key   = k;
        key_valid = 1'b0;
        break;
      end
      if (in_ready) chk1("drain_in_ready", in_ready, 1'b0);
    end
    if (ack_cyc < 0) chk1("key_ack_timeout", 1'b1, 1'b0);
  endtask

  task automatic drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk1(nm, ok, 1'b1);
  endtask

  task automatic reset_checks(input string tg);
    chk1({tg, "_key_ack"},   key_ack,   1'b0);
    chk1({tg, "_in_ready"},  in_ready,  1'b0);
    chk1({tg, "_out_valid"}, out_valid, 1'b0);
    chk ({tg, "_out_data"},  out_data,  128'h0);
    chk ({tg, "_blk_count"}, {96'h0, blk_count}, 128'h0);
    chk1({tg, "_busy"},      busy,      1'b1);
    chk1({tg, "_issue"},     core_data[128], 1'b0);
    chk ({tg, "_key_hi"},    core_key[1407:1280], 128'h0);
    chk ({tg, "_key_lo"},    core_key[127:0],     128'h0);
  endtask

  task automatic nokey_check(input string tg);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_data = rnd128();
      @(negedge clk);
      chk1({tg, "_in_ready"},  in_ready,       1'b0);
      chk1({tg, "_issue"},     core_data[128], 1'b0);
      chk1({tg, "_out_valid"}, out_valid,      1'b0);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int            a, b, c, prev, nacc, ack;
    logic [127:0]  d;
    logic [1407:0] k;
    bit            ok;
    logic [31:0]   exp_bc;

    n_rst = 1'b0; key_valid = 1'b0; key_in = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    n_rst = 1'b1;
    tick();
    nokey_check("nokey");

    // FIPS-197 vector
    k = key_expand(128'h000102030405060708090a0b0c0d0e0f);
    out_ready = 1'b1;
    load_key(k, ack);
    for (int r = 0; r < 11; r++)
      chk("core_key", core_key[1407-128*r -: 128], k[1407-128*r -: 128]);
    send(128'h00112233445566778899aabbccddeeff, a);
    in_valid = 1'b0;
    ok = 1'b0; b = 0; d = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1; b = cyc; d = out_data;
        break;
      end
    end
    tick();
    chk1("fips_timeout", ok, 1'b1);
    chki("fips_latency", b - a, PIPE_LAT + 1);
    chk("fips_ct", d, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    drain("fips_drain");

    // Streaming
    pop_cyc.delete();
    prev = 0;
    for (int i = 0; i < 32; i++) begin
      send(rnd128(), c);
      if (i > 0) chki("stream_gap", c, prev + 1);
      prev = c;
    end
    in_valid = 1'b0;
    drain("stream_drain");
    chki("stream_count", pop_cyc.size(), 32);
    if (pop_cyc.size() == 32)
      chki("stream_rate", pop_cyc[31] - pop_cyc[0], 31);

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    nacc = 0;
    for (int i = 0; i < 60; i++) begin
      in_data = rnd128();
      @(negedge clk);
      if (in_ready) nacc++;
      if (out_valid && exp_q.size() > 0) chk("bp_head_hold", out_data, exp_q[0]);
      tick();
    end
    chki("bp_accepts", nacc, FIFO_DEPTH);
    chk1("bp_in_ready", in_ready, 1'b0);
    chk1("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_data = rnd128();
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    chk1("bp_resume", ok, 1'b1);
    in_valid = 1'b0;
    drain("bp_drain");

    // Key change with five blocks in flight
    for (int i = 0; i < 5; i++) send(rnd128(), a);
    in_data = rnd128();
    load_key(key_expand(rnd128()), ack);
    chki("key_ack_cycle", ack, a + PIPE_LAT + 1);
    for (int i = 0; i < 5; i++) send(rnd128(), c);
    in_valid = 1'b0;
    drain("key_drain");

    // Reset with 7 in flight and 3 stored
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(rnd128(), c);
    in_valid = 1'b0;
    repeat (3) tick();
    chk1("pre_rst_out_valid", out_valid, 1'b1);
    n_rst = 1'b0;
    #1;
    reset_checks("midrst");
    exp_q.delete();
    pushes = 0;
    repeat (2) tick();
    n_rst = 1'b1;
    out_ready = 1'b1;
    nokey_check("postrst");

    // Randomized traffic with a key change midway
    load_key(key_expand(rnd128()), ack);
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rnd128();
      out_ready = ($urandom_range(0, 2) != 0);
      if (i == 150) load_key(key_expand(rnd128()), ack);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");
    chki("rand_sb_left", exp_q.size(), 0);
`ifdef ENC_SCHED_STATS_EN
    exp_bc = 32'(pushes);
`else
    exp_bc = 32'h0;
`endif
    chk("blk_count", {96'h0, blk_count}, {96'h0, exp_bc});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
